sc_point_datapath: RTL and testbench
====================================

// Module: sc_point_datapath
// PURPOSE
//  Datapath stage directly downstream of the point/car control FSM.
//  - Executes its low-active command strobes: clear, load, left/right shift, point-check and up-count.
//  - Holds the player point (one-hot), the current obstacle row and the score.
//  - Detects point/row collisions and generates the WAIT level that the FSM consumes.
// PARAMETERS
//  WIDTH        8   width of point and row registers (display columns)
//  INIT_IDX     4   bit index of the point after reset/clear
//  SCORE_WIDTH  8   score counter width
//  UPCOUNT_DIV  4   up-count strobes per score increment (>=1)
//  WAIT_CYCLES  16  cycles wait_Out stays high after a collision (>=1)
// PORTS
//  SC_STATEMACHINEPOINT_CLOCK_50        in   1      system clock
//  SC_STATEMACHINEPOINT_RESET_InHigh    in   1      async reset, active-high
//  SC_POINTDP_clear_InLow               in   1      0: clear point/score/flags
//  SC_POINTDP_load0_InLow               in   1      0: load row register from row_In
//  SC_POINTDP_shiftselection_In         in   2      01 left, 10 right, 11/00 hold
//  SC_POINTDP_POINTselection_In         in   1      1: collision check strobe
//  SC_POINTDP_upcount_InLow             in   1      0: one up-count strobe
//  SC_POINTDP_row_In                    in   WIDTH  next obstacle row
//  SC_POINTDP_point_Out                 out  WIDTH  one-hot player point
//  SC_POINTDP_row_Out                   out  WIDTH  current obstacle row
//  SC_POINTDP_score_Out                 out  SCORE_WIDTH  score
//  SC_POINTDP_crash_Out                 out  1      sticky collision flag
//  SC_POINTDP_wait_Out                  out  1      to FSM WAIT input
// BEHAVIOUR
//  Clock and reset
//  - Reset SC_STATEMACHINEPOINT_RESET_InHigh: asynchronous, active-high.
//  - Clock SC_STATEMACHINEPOINT_CLOCK_50.
//  - All outputs are registered.
//  - Reset values: point=1<<INIT_IDX, row=0, score=0, div=0, crash=0, wait=0, wait counter=0.
//  Command timing
//  - Every command takes effect on the next rising edge (1-cycle latency).
//  Clear
//  - clear_InLow=0 has priority over every other input in the same cycle.
//  - Sets point=1<<INIT_IDX, score=0, div=0, crash=0, wait=0.
//  - Cancels any active wait window.
//  - Row is NOT cleared.
//  Shift
//  - Left: point<<1. Right: point>>1.
//  - Saturating: left at bit WIDTH-1 and right at bit 0 leave point unchanged (no wrap).
//  Load
//  - load0_InLow=0: row<=row_In.
//  - Independent of shift; load and shift in the same cycle both execute.
//  Collision check (POINTselection_In=1)
//  - Evaluates |(point & row) using pre-edge register values.
//  - Hit: crash<=1 (sticky until clear), wait<=1, wait counter<=WAIT_CYCLES-1.
//  Wait window
//  - wait_Out is high for exactly WAIT_CYCLES cycles, starting the edge after the check.
//  - The counter decrements each cycle; wait drops on the edge after the counter reaches 0.
//  - Checks arriving while wait=1 are ignored (no retrigger).
//  - Up-count strobes arriving while wait=1 are ignored.
//  Up-count
//  - Each strobe increments the 0..UPCOUNT_DIV-1 divider.
//  - When the divider wraps to 0, score increments by 1.
//  - Score saturates at 2^SCORE_WIDTH-1; the divider keeps running at saturation.
//  Operation control states (1 explicit register)
//  - RUN: wait=0.
//  - HOLD: wait=1.
//  - RUN->HOLD on a hit.
//  - HOLD->RUN on counter==0 or on clear.
//  - Reset mid-HOLD returns to RUN immediately (asynchronous).
// STRUCTURE
//  Shared package sc_point_pkg
//  - Shift encodings SHIFT_LEFT=2'b01, SHIFT_RIGHT=2'b10, SHIFT_HOLD=2'b11.
//  - RUN/HOLD state encodings.
//  - Also imported by the control FSM.
//  Sub-module sc_point_scorecounter
//  - Contains the divider and the saturating score counter.
//  - Inputs: enable (upcount & ~wait) and clear.
//  Top level
//  - Point shifter, row register, collision compare and the wait timer.
// TESTING
//  1. Reset, then idle
//     -> point=8'h10, row=0, score=0, crash=0, wait=0.
//  2. 5 left strobes from reset
//     -> point 20,40,80,80,80 (saturates).
//     Then 8 right strobes -> ends at 8'h01.
//  3. 8 up-count strobes, DIV=4
//     -> score=2.
//     With SCORE_WIDTH=8 and 1024 strobes -> score=8'hFF and holds.
//  4. Load row=8'h10 with point=8'h10, then check strobe
//     -> next cycle crash=1, wait=1 for exactly 16 cycles.
//     A second check mid-window does not extend it.
//     Up-count strobes are ignored during the window.
//  5. clear=0 during the wait window
//     -> next edge wait=0, crash=0, score=0, point=8'h10, row unchanged.
//  6. Reset asserted mid-window with load and left in the same cycle
//     -> async return to reset values.
//     Also: a load+left cycle without reset updates both registers.

Source files
------------

// File: rtl/sc_point_pkg.sv
// Shared encodings for the point/car control FSM and its datapath stage.
package sc_point_pkg;

  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;
  localparam logic [1:0] SHIFT_HOLD  = 2'b11;

  // Operation control: RUN accepts checks/up-counts, HOLD is the post-collision wait window.
  localparam logic [0:0] OP_RUN  = 1'b0;
  localparam logic [0:0] OP_HOLD = 1'b1;

endpackage

// File: rtl/sc_point_scorecounter.sv
// Up-count divider feeding a saturating score counter.
module sc_point_scorecounter #(
  parameter int SCORE_WIDTH = 8,
  parameter int UPCOUNT_DIV = 4
) (
  input  logic                   SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic                   SC_STATEMACHINEPOINT_RESET_InHigh,
  input  logic                   clear,
  input  logic                   enable,
  output logic [SCORE_WIDTH-1:0] score
);

  localparam int DIV_W = (UPCOUNT_DIV > 1) ? $clog2(UPCOUNT_DIV) : 1;
  localparam logic [DIV_W-1:0]       DIV_LAST  = DIV_W'(UPCOUNT_DIV - 1);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;

  logic [DIV_W-1:0] div;

  // The divider keeps wrapping after the score saturates.
  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      div   <= '0;
      score <= '0;
    end else if (clear) begin
      div   <= '0;
      score <= '0;
    end else if (enable) begin
      if (div == DIV_LAST) begin
        div <= '0;
        if (score != SCORE_MAX) score <= score + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sc_point_datapath.sv
// Point/row/score datapath downstream of the point control FSM; raises WAIT after a collision.
module sc_point_datapath
  import sc_point_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int INIT_IDX    = 4,
  parameter int SCORE_WIDTH = 8,
  parameter int UPCOUNT_DIV = 4,
  parameter int WAIT_CYCLES = 16
) (
  input  logic                   SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic                   SC_STATEMACHINEPOINT_RESET_InHigh,
  input  logic                   SC_POINTDP_clear_InLow,
  input  logic                   SC_POINTDP_load0_InLow,
  input  logic [1:0]             SC_POINTDP_shiftselection_In,
  input  logic                   SC_POINTDP_POINTselection_In,
  input  logic                   SC_POINTDP_upcount_InLow,
  input  logic [WIDTH-1:0]       SC_POINTDP_row_In,
  output logic [WIDTH-1:0]       SC_POINTDP_point_Out,
  output logic [WIDTH-1:0]       SC_POINTDP_row_Out,
  output logic [SCORE_WIDTH-1:0] SC_POINTDP_score_Out,
  output logic                   SC_POINTDP_crash_Out,
  output logic                   SC_POINTDP_wait_Out
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WIDTH-1:0] INIT_POINT = {{(WIDTH-1){1'b0}}, 1'b1} << INIT_IDX;
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT_CYCLES - 1);

  // Command strobes are levels sampled on every rising edge; there is no handshake,
  // each asserted strobe acts exactly once per cycle it is held.
  logic [WIDTH-1:0] point;
  logic [WIDTH-1:0] row;
  logic             crash;
  logic [0:0]       opState;
  logic [CNT_W-1:0] waitCnt;
  logic             clear;
  logic             hit;
  logic             checkFire;
  logic             countEn;

  assign clear     = ~SC_POINTDP_clear_InLow;
  assign hit       = |(point & row);
  assign checkFire = SC_POINTDP_POINTselection_In && (opState == OP_RUN) && hit;
  assign countEn   = ~SC_POINTDP_upcount_InLow && (opState == OP_RUN);

  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      point <= INIT_POINT;
    end else if (clear) begin
      point <= INIT_POINT;
    end else begin
      case (SC_POINTDP_shiftselection_In)
        SHIFT_LEFT:  if (!point[WIDTH-1]) point <= point << 1;
        SHIFT_RIGHT: if (!point[0])       point <= point >> 1;
        default:     point <= point;
      endcase
    end
  end

  // Clear outranks load, so the row simply holds during a clear cycle.
  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      row <= '0;
    end else if (!clear && !SC_POINTDP_load0_InLow) begin
      row <= SC_POINTDP_row_In;
    end
  end

  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      opState <= OP_RUN;
      waitCnt <= '0;
      crash   <= 1'b0;
    end else if (clear) begin
      opState <= OP_RUN;
      waitCnt <= '0;
      crash   <= 1'b0;
    end else if (opState == OP_RUN) begin
      if (checkFire) begin
        opState <= OP_HOLD;
        waitCnt <= WAIT_LOAD;
        crash   <= 1'b1;
      end
    end else begin
      if (waitCnt == '0) opState <= OP_RUN;
      else               waitCnt <= waitCnt - 1'b1;
    end
  end

  sc_point_scorecounter #(
    .SCORE_WIDTH(SCORE_WIDTH),
    .UPCOUNT_DIV(UPCOUNT_DIV)
  ) u_scorecounter (
    .SC_STATEMACHINEPOINT_CLOCK_50    (SC_STATEMACHINEPOINT_CLOCK_50),
    .SC_STATEMACHINEPOINT_RESET_InHigh(SC_STATEMACHINEPOINT_RESET_InHigh),
    .clear                            (clear),
    .enable                           (countEn),
    .score                            (SC_POINTDP_score_Out)
  );

  // wait_Out is the RUN/HOLD state flop itself, so the control state is directly observable.
  assign SC_POINTDP_point_Out = point;
  assign SC_POINTDP_row_Out   = row;
  assign SC_POINTDP_crash_Out = crash;
  assign SC_POINTDP_wait_Out  = opState[0];

endmodule

// File: tb/tb_sc_point_datapath.sv
// Directed scoreboard bench for sc_point_datapath: driver pushes expected outputs, monitor compares after each edge.
module tb_sc_point_datapath;

  localparam logic [1:0] SH_NONE  = 2'b00;
  localparam logic [1:0] SH_LEFT  = 2'b01;
  localparam logic [1:0] SH_RIGHT = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clearL = 1'b1;
  logic       loadL = 1'b1;
  logic [1:0] shiftSel = SH_NONE;
  logic       pointSel = 1'b0;
  logic       upL = 1'b1;
  logic [7:0] rowIn = 8'h00;
  logic [7:0] pointOut;
  logic [7:0] rowOut;
  logic [7:0] scoreOut;
  logic       crashOut;
  logic       waitOut;

  logic [7:0] ePoint = 8'h10;
  logic [7:0] eRow = 8'h00;
  logic [7:0] eScore = 8'h00;
  logic       eCrash = 1'b0;
  logic       eWait = 1'b0;

  logic [25:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          failures = 0;

  sc_point_datapath dut (
    .SC_STATEMACHINEPOINT_CLOCK_50    (clk),
    .SC_STATEMACHINEPOINT_RESET_InHigh(rst),
    .SC_POINTDP_clear_InLow           (clearL),
    .SC_POINTDP_load0_InLow           (loadL),
    .SC_POINTDP_shiftselection_In     (shiftSel),
    .SC_POINTDP_POINTselection_In     (pointSel),
    .SC_POINTDP_upcount_InLow         (upL),
    .SC_POINTDP_row_In                (rowIn),
    .SC_POINTDP_point_Out             (pointOut),
    .SC_POINTDP_row_Out               (rowOut),
    .SC_POINTDP_score_Out             (scoreOut),
    .SC_POINTDP_crash_Out             (crashOut),
    .SC_POINTDP_wait_Out              (waitOut)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [25:0] expVec();
    return {ePoint, eRow, eScore, eCrash, eWait};
  endfunction

  task automatic compare(input logic [25:0] expected, input string tag);
    logic [25:0] got;
    got = {pointOut, rowOut, scoreOut, crashOut, waitOut};
    checks++;
    if (got !== expected) begin
      failures++;
      $display("FAIL %s: point/row/score/crash/wait got=%h/%h/%h/%b/%b required=%h/%h/%h/%b/%b",
               tag, got[25:18], got[17:10], got[9:2], got[1], got[0],
               expected[25:18], expected[17:10], expected[9:2], expected[1], expected[0]);
    end
  endtask

  // driver: apply one cycle of inputs and queue the outputs expected after the next edge
  task automatic step(input logic cl, input logic ld, input logic [1:0] sh, input logic chk,
                      input logic up, input logic [7:0] rin, input string tag);
    @(negedge clk);
    clearL   = cl;
    loadL    = ld;
    shiftSel = sh;
    pointSel = chk;
    upL      = up;
    rowIn    = rin;
    exp_q.push_back(expVec());
    tag_q.push_back(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b1, 1'b1, SH_NONE, 1'b0, 1'b1, 8'h00, tag);
  endtask

  // monitor
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) compare(exp_q.pop_front(), tag_q.pop_front());
  end

  logic [7:0] leftTab[5]  = '{8'h20, 8'h40, 8'h80, 8'h80, 8'h80};
  logic [7:0] rightTab[8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h01};

  initial begin
    // 1. reset and idle
    repeat (2) @(posedge clk);
    #1 compare(expVec(), "reset_held");
    @(negedge clk);
    rst = 1'b0;
    idle("reset_idle");
    idle("reset_idle2");

    // 2. saturating shifts
    for (int i = 0; i < 5; i++) begin
      ePoint = leftTab[i];
      step(1'b1, 1'b1, SH_LEFT, 1'b0, 1'b1, 8'h00, "shift_left");
    end
    for (int i = 0; i < 8; i++) begin
      ePoint = rightTab[i];
      step(1'b1, 1'b1, SH_RIGHT, 1'b0, 1'b1, 8'h00, "shift_right");
    end
    step(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 8'h00, "shift_hold11");

    // 3. up-count, divide by 4, then saturation
    for (int i = 0; i < 8; i++) begin
      eScore = 8'((i + 1) / 4);
      step(1'b1, 1'b1, SH_NONE, 1'b0, 1'b0, 8'h00, "upcount_div");
    end
    for (int i = 0; i < 1024; i++) begin
      int n;
      n = (8 + i + 1) / 4;
      eScore = (n > 255) ? 8'hFF : 8'(n);
      step(1'b1, 1'b1, SH_NONE, 1'b0, 1'b0, 8'h00, "upcount_sat");
    end
    idle("score_hold_ff");

    // 4. collision and wait window
    ePoint = 8'h10; eScore = 8'h00;
    step(1'b0, 1'b1, SH_NONE, 1'b0, 1'b1, 8'h00, "clear_before_hit");
    eRow = 8'h01;
    step(1'b1, 1'b0, SH_NONE, 1'b0, 1'b1, 8'h01, "load_row01");
    step(1'b1, 1'b1, SH_NONE, 1'b1, 1'b1, 8'h00, "check_miss");
    eRow = 8'h10;
    step(1'b1, 1'b0, SH_NONE, 1'b0, 1'b1, 8'h10, "load_row10");
    eCrash = 1'b1; eWait = 1'b1;
    step(1'b1, 1'b1, SH_NONE, 1'b1, 1'b1, 8'h00, "check_hit");
    for (int k = 1; k <= 16; k++) begin
      eWait = (k < 16);
      step(1'b1, 1'b1, SH_NONE, (k == 5), 1'b0, 8'h00, "wait_window");
    end
    idle("wait_done_crash_sticky");

    // 5. clear inside the wait window outranks load/shift/check/upcount
    for (int k = 1; k <= 4; k++) begin
      eScore = 8'(k / 4);
      step(1'b1, 1'b1, SH_NONE, 1'b0, 1'b0, 8'h00, "upcount_pre_clear");
    end
    eWait = 1'b1;
    step(1'b1, 1'b1, SH_NONE, 1'b1, 1'b1, 8'h00, "check_hit2");
    repeat (3) idle("wait_before_clear");
    ePoint = 8'h10; eScore = 8'h00; eCrash = 1'b0; eWait = 1'b0;
    step(1'b0, 1'b0, SH_LEFT, 1'b1, 1'b0, 8'hAA, "clear_in_window");
    idle("after_clear");

    // 6. load+left together, then async reset mid-window
    ePoint = 8'h20; eRow = 8'h3C;
    step(1'b1, 1'b0, SH_LEFT, 1'b0, 1'b1, 8'h3C, "load_and_left");
    eRow = 8'h20;
    step(1'b1, 1'b0, SH_NONE, 1'b0, 1'b1, 8'h20, "load_row20");
    eCrash = 1'b1; eWait = 1'b1;
    step(1'b1, 1'b1, SH_NONE, 1'b1, 1'b1, 8'h00, "check_hit3");
    repeat (2) idle("wait_before_reset");
    @(negedge clk);
    loadL = 1'b0; rowIn = 8'hFF; shiftSel = SH_LEFT;
    ePoint = 8'h10; eRow = 8'h00; eScore = 8'h00; eCrash = 1'b0; eWait = 1'b0;
    #2 rst = 1'b1;
    #1 compare(expVec(), "async_reset_mid_window");
    @(posedge clk);
    #1 compare(expVec(), "reset_held_with_load_left");
    @(negedge clk);
    rst = 1'b0; loadL = 1'b1; rowIn = 8'h00; shiftSel = SH_NONE;
    idle("post_reset_idle");

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
